// File: rtl/codec_intf.sv
// Serial codec link: generates the codec clocks and reset, deserializes ADC data, serializes DAC data.
// Optional `CODEC_SDOUT_SYNC_EN` adds a 2-flop SDout synchronizer and moves the capture point later.
module codec_intf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] lft_out,
   input  logic [15:0] rht_out,
   input  logic        SDout,
   output logic [15:0] lft_in,
   output logic [15:0] rht_in,
   output logic        valid,
   output logic        LRCLK,
   output logic        SCLK,
   output logic        MCLK,
   output logic        SDin,
   output logic        RSTn
);

   logic [9:0]  cnt_q, cnt_d;
   logic [15:0] rx_q, rx_d;
   logic [15:0] lft_hold_q, lft_hold_d;
   logic [15:0] tx_q, tx_d;
   logic [15:0] rht_shadow_q, rht_shadow_d;
   logic [15:0] lft_in_d, rht_in_d;
   logic        valid_d, rstn_d;
   logic        frame_end, half_end;
   logic        sd_cap;

`ifdef CODEC_SDOUT_SYNC_EN
   localparam logic [4:0] CapPhase = 5'h19;
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= SDout;
         sync2_q <= sync1_q;
      end
   end

   assign sd_cap = sync2_q;
`else
   localparam logic [4:0] CapPhase = 5'h17;

   assign sd_cap = SDout;
`endif

   always_comb begin
      cnt_d        = cnt_q + 10'd1;
      frame_end    = (cnt_q == 10'h3FF);
      half_end     = (cnt_q == 10'h1FF);
      rx_d         = rx_q;
      lft_hold_d   = lft_hold_q;
      lft_in_d     = lft_in;
      rht_in_d     = rht_in;
      tx_d         = tx_q;
      rht_shadow_d = rht_shadow_q;
      valid_d      = 1'b0;
      rstn_d       = RSTn | frame_end;

      if (cnt_q[4:0] == CapPhase) begin
         rx_d = {rx_q[14:0], sd_cap};
      end
      if (half_end) begin
         lft_hold_d = rx_q;
      end
      if (frame_end) begin
         lft_in_d = lft_hold_q;
         rht_in_d = rx_q;
         // No strobe in the first frame: the codec was still held in reset.
         valid_d  = RSTn;
      end

      // Word loads coincide with an SCLK falling edge and win over the shift.
      if (frame_end) begin
         tx_d         = lft_out;
         rht_shadow_d = rht_out;
      end else if (half_end) begin
         tx_d = rht_shadow_q;
      end else if (cnt_q[4:0] == 5'h1F) begin
         tx_d = {tx_q[14:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         rx_q         <= '0;
         lft_hold_q   <= '0;
         tx_q         <= '0;
         rht_shadow_q <= '0;
         lft_in       <= '0;
         rht_in       <= '0;
         valid        <= 1'b0;
         RSTn         <= 1'b0;
         SDin         <= 1'b0;
         LRCLK        <= 1'b0;
         SCLK         <= 1'b0;
         MCLK         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         rx_q         <= rx_d;
         lft_hold_q   <= lft_hold_d;
         tx_q         <= tx_d;
         rht_shadow_q <= rht_shadow_d;
         lft_in       <= lft_in_d;
         rht_in       <= rht_in_d;
         valid        <= valid_d;
         RSTn         <= rstn_d;
         SDin         <= tx_q[15];
         // Clocks track the next count so they change on the same edge as cnt.
         LRCLK        <= cnt_d[9];
         SCLK         <= cnt_d[4];
         MCLK         <= cnt_d[1];
      end
   end

endmodule

// File: tb/tb_codec_intf.sv
// Self-checking bench for codec_intf: table-driven frames, a codec/core model and scoreboards
// for received words and serialized DAC words.
module tb_codec_intf;

   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
   } pair_t;

   typedef struct {
      logic [15:0] codec_l;
      logic [15:0] codec_r;
      logic [15:0] core_l;
      logic [15:0] core_r;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] lft_out, rht_out, lft_in, rht_in;
   logic        sdout, valid, lrclk, sclk, mclk, sdin, rstn_c;

   always #5 clk = ~clk;

   codec_intf dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .lft_out(lft_out),
      .rht_out(rht_out),
      .SDout  (sdout),
      .lft_in (lft_in),
      .rht_in (rht_in),
      .valid  (valid),
      .LRCLK  (lrclk),
      .SCLK   (sclk),
      .MCLK   (mclk),
      .SDin   (sdin),
      .RSTn   (rstn_c)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 20) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame timing model.
   logic [9:0] mcnt;
   logic       rstn_m, valid_m;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt    <= '0;
         rstn_m  <= 1'b0;
         valid_m <= 1'b0;
      end else begin
         valid_m <= (mcnt == 10'h3FF) && rstn_m;
         if (mcnt == 10'h3FF) rstn_m <= 1'b1;
         mcnt <= mcnt + 10'd1;
      end
   end

   // Codec model: MSB-first, bit changes on the SCLK falling edge (bit boundary).
   logic [15:0] codec_l = '0;
   logic [15:0] codec_r = '0;
   logic [3:0]  bit_idx;
   assign bit_idx = 4'd15 - mcnt[8:5];
   assign sdout   = mcnt[9] ? codec_r[bit_idx] : codec_l[bit_idx];

   pair_t       rx_q[$];
   pair_t       tx_q[$];
   logic [15:0] cap_l, cap_r;
   logic        mon_en = 1'b0;

   always @(negedge clk) begin
      pair_t p;
      if (mon_en && rst_n) begin
         chk("mclk", 32'(mclk), 32'(mcnt[1]));
         chk("sclk", 32'(sclk), 32'(mcnt[4]));
         chk("lrclk", 32'(lrclk), 32'(mcnt[9]));
         chk("rstn", 32'(rstn_c), 32'(rstn_m));
         chk("valid", 32'(valid), 32'(valid_m));
         if (valid) begin
            if (rx_q.size() == 0) begin
               chk("valid_without_expect", 32'(rx_q.size()), 32'd1);
            end else begin
               p = rx_q.pop_front();
               chk("lft_in", 32'(lft_in), 32'(p.l));
               chk("rht_in", 32'(rht_in), 32'(p.r));
            end
         end
         if (mcnt[4:0] == 5'h10) begin
            if (!mcnt[9]) cap_l = {cap_l[14:0], sdin};
            else          cap_r = {cap_r[14:0], sdin};
         end
         if (mcnt == 10'h3FF) begin
            if (tx_q.size() == 0) begin
               chk("tx_sb_nonempty", 32'(tx_q.size()), 32'd1);
            end else begin
               p = tx_q.pop_front();
               chk("sdin_left", 32'(cap_l), 32'(p.l));
               chk("sdin_right", 32'(cap_r), 32'(p.r));
            end
            tx_q.push_back({lft_out, rht_out});
         end
      end
   end

   task automatic wait_cnt(input logic [9:0] target);
      for (int i = 0; i < 2048; i++) begin
         @(posedge clk);
         #1;
         if (mcnt == target) return;
      end
      chk("wait_timeout", 32'(mcnt), 32'(target));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_lft_in"}, 32'(lft_in), 32'd0);
      chk({tag, "_rht_in"}, 32'(rht_in), 32'd0);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_sdin"}, 32'(sdin), 32'd0);
      chk({tag, "_rstn"}, 32'(rstn_c), 32'd0);
      chk({tag, "_lrclk"}, 32'(lrclk), 32'd0);
      chk({tag, "_sclk"}, 32'(sclk), 32'd0);
      chk({tag, "_mclk"}, 32'(mclk), 32'd0);
   endtask

   task automatic clear_sb();
      rx_q.delete();
      tx_q.delete();
      tx_q.push_back('0);
      cap_l = '0;
      cap_r = '0;
   endtask

   // Called with mcnt == 0; core words are garbage until 0x100 and must not leak into SDin.
   task automatic start_frame(input vec_t v);
      codec_l = v.codec_l;
      codec_r = v.codec_r;
      lft_out = ~v.core_l;
      rht_out = ~v.core_r;
      if (rstn_m) rx_q.push_back({v.exp_l, v.exp_r});
      wait_cnt(10'h100);
      lft_out = v.core_l;
      rht_out = v.core_r;
   endtask

   vec_t vec[4];

   initial begin
      vec[0] = '{16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, 16'hA5C3, 16'h1234};
      vec[1] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
      vec[2] = '{16'h0001, 16'h8000, 16'h5A5A, 16'hA5A5, 16'h0001, 16'h8000};
      vec[3] = '{16'h7FFE, 16'h8001, 16'h1357, 16'h9BDF, 16'h7FFE, 16'h8001};

      rst_n   = 1'b0;
      lft_out = '0;
      rht_out = '0;
      clear_sb();
      repeat (3) @(posedge clk);
      #2;
      check_zero("por");
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int k = 0; k < 5; k++) begin
         start_frame(vec[k % 4]);
         wait_cnt(10'h000);
      end

      // Abort in the middle of the right word.
      start_frame(vec[1]);
      wait_cnt(10'h250);
      rst_n = 1'b0;
      clear_sb();
      #2;
      check_zero("midrst");
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      for (int k = 0; k < 3; k++) begin
         start_frame(vec[(k + 2) % 4]);
         wait_cnt(10'h000);
      end

      repeat (4) @(posedge clk);
      chk("rx_sb_empty", 32'(rx_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/codec_intf.md
Name: codec_intf

Overview:
- Serial codec link that feeds the digital equalizer core and drains it. Samples the codec's serial ADC stream into left/right 16-bit words with a one-cycle `valid` strobe.
- Serializes the core's processed left/right words back to the codec DAC.
- Generates all codec clocks (MCLK, SCLK, LRCLK) and the codec reset from the system clock.
- Sits between the pad ring and the digital core: its `lft_in`/`rht_in`/`valid` drive the core's inputs, and its `lft_out`/`rht_out` inputs take the core's outputs.

Parameters:
- None. Timing is fixed: 1024 clk per stereo frame, 16-bit MSB-first left-justified words.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- lft_out  input  16  processed left sample from core (signed)
- rht_out  input  16  processed right sample from core (signed)
- SDout  input  1  serial ADC data from codec, changes on SCLK falling
- lft_in  output  16  received left sample to core
- rht_in  output  16  received right sample to core
- valid  output  1  one-clk strobe: lft_in/rht_in updated this cycle
- LRCLK  output  1  frame clock, 0 = left half, 1 = right half
- SCLK  output  1  bit clock, 16 periods per LRCLK half
- MCLK  output  1  codec master clock, clk/4
- SDin  output  1  serial DAC data to codec
- RSTn  output  1  codec reset, active low

Behaviour:
- Reset (async, rst_n=0) forces:
  - 10-bit free-running counter `cnt` = 0.
  - All outputs 0: lft_in, rht_in, valid, SDin, RSTn, LRCLK, SCLK, MCLK.
  - All internal shift/hold registers = 0.
- Clock generation:
  - LRCLK, SCLK and MCLK are registered copies of the next value of cnt[9], cnt[4] and cnt[1], so they are glitch-free.
  - SCLK rises when cnt[4:0] goes 0x0F->0x10 and falls when it goes 0x1F->0x00.
- Codec reset:
  - RSTn goes 1 on the cycle after the first cnt==0x3FF and stays 1 until rst_n is asserted.
- Receive:
  - 16-bit rx shift register shifts left, inserting SDout at the LSB, on every clk where cnt[4:0]==0x17 (mid SCLK-high).
  - At cnt==0x1FF: lft_hold <= rx shift register.
  - At cnt==0x3FF: lft_in <= lft_hold and rht_in <= rx shift register.
  - valid=1 for exactly the clk after that update, and only if RSTn was already 1 at cnt==0x3FF. The first frame after reset therefore produces no valid.
  - Latency from the right LSB captured (cnt==0x3F7) to valid is 9 clk.
- Transmit:
  - At cnt==0x3FF: sample lft_out and rht_out. Load the left word into the 16-bit tx shift register and the right word into rht_shadow.
  - At cnt==0x1FF: tx shift register <= rht_shadow.
  - On every other clk where cnt[4:0]==0x1F (SCLK falling): shift left by one, filling with 0.
  - SDin = tx shift register bit 15, registered, so the MSB is stable before the first SCLK rise of each half.
  - A word sampled at frame k is transmitted in frame k+1.
- Boundary conditions:
  - At cnt==0x1FF and 0x3FF, the load takes priority over the shift (cnt[4:0]==0x1F coincides).
  - cnt wraps 0x3FF->0x000 with no gap; frames are back-to-back.
  - lft_out/rht_out are ignored except on the cnt==0x3FF cycle.
  - Reset mid-frame aborts immediately: the partial word is discarded, no valid is issued, SDin=0, and RSTn=0 again.
- Data is passed through unmodified (no sign extension or arithmetic); 16 bits in, 16 bits out.

Optional Feature:
- Macro `CODEC_SDOUT_SYNC_EN`.
- Defined:
  - SDout passes through a 2-flop synchronizer (reset 0) before the rx shift register.
  - The capture point moves to cnt[4:0]==0x19.
  - Hold/update points (0x1FF/0x3FF) are unchanged; the right LSB is captured at cnt==0x3F9.
- Undefined:
  - Raw SDout is captured at cnt[4:0]==0x17, with no synchronizer flops.

Test Plan:
- Reset release, idle SDout=0:
  - RSTn stays 0 until cnt==0x3FF, then 1.
  - No valid in the first frame; valid pulses once per 1024 clk thereafter.
  - MCLK period is 4 clk, SCLK 32 clk, LRCLK 1024 clk.
- Codec model drives left 0xA5C3 and right 0x1234 MSB-first on SCLK falling:
  - Next valid shows lft_in=0xA5C3, rht_in=0x1234 for that frame.
  - valid is high exactly 1 clk.
- Core drives lft_out=0x8001 and rht_out=0x7FFE at cnt==0x3FF:
  - Next frame, SDin sampled on SCLK rising gives 0x8001 while LRCLK=0 and 0x7FFE while LRCLK=1.
- lft_out/rht_out change at cnt==0x100 within the frame:
  - The serialized words are the values present at cnt==0x3FF only.
- Assert rst_n at cnt==0x250 mid right word:
  - All outputs are 0 asynchronously.
  - After release, the first valid appears only after the second 0x3FF wrap, with no corrupted partial word.
- With `CODEC_SDOUT_SYNC_EN` defined:
  - The same 0xA5C3/0x1234 stimulus yields identical lft_in/rht_in, and valid still occurs 1 clk after cnt==0x3FF.
